ram_burst_reader: RTL and testbench



---
 rtl/ram_burst_reader_if.sv | 32 +++
 rtl/ram_burst_reader.sv | 104 ++++++++++
 tb/tb_ram_burst_reader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if: request, RAM port-B and output stream signals of the burst reader
interface ram_burst_reader_if #(
   parameter int DATA_DEPTH = 256,
   parameter int DATA_WIDTH = 32
);
   localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
   localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

   logic                  req_valid_i;
   logic                  req_ready_o;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [LEN_WIDTH-1:0]  req_len_i;
   logic                  ram_en_o;
   logic [ADDR_WIDTH-1:0] ram_addr_o;
   logic [DATA_WIDTH-1:0] ram_data_i;
   logic                  data_valid_o;
   logic                  data_ready_i;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  data_last_o;
   logic                  done_o;
   logic                  busy_o;

   modport slave (
      input  req_valid_i, req_addr_i, req_len_i, ram_data_i, data_ready_i,
      output req_ready_o, ram_en_o, ram_addr_o, data_valid_o, data_o, data_last_o, done_o, busy_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_len_i, ram_data_i, data_ready_i,
      input  req_ready_o, ram_en_o, ram_addr_o, data_valid_o, data_o, data_last_o, done_o, busy_o
   );
endinterface

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: issues wrapped port-B burst reads and streams the words through a 2-entry buffer
module ram_burst_reader #(
   parameter int DATA_DEPTH = 256,
   parameter int DATA_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   ram_burst_reader_if.slave  bus
);
   localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
   localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, last_addr_q, last_addr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d, len_clamped;
   logic                  inflight_q, inflight_last_q;
   logic [DATA_WIDTH-1:0] buf_data_q [2];
   logic [1:0]            buf_last_q;
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            count_q;
   logic                  accept, credit, issue, push, pop, drained;

   // buffered words plus the word in flight, after this cycle's pop, must leave room for one more
   assign credit      = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));
   assign issue       = (state_q == READ) && (rem_q != '0) && credit;
   assign accept      = bus.req_valid_i && (state_q == IDLE);
   assign push        = inflight_q;
   assign pop         = bus.data_valid_o && bus.data_ready_i;
   assign drained     = !inflight_q && (count_q == '0);
   assign len_clamped = (bus.req_len_i > LEN_WIDTH'(DATA_DEPTH)) ? LEN_WIDTH'(DATA_DEPTH) : bus.req_len_i;

   assign bus.req_ready_o  = (state_q == IDLE);
   assign bus.busy_o       = (state_q != IDLE);
   assign bus.ram_en_o     = issue;
   assign bus.ram_addr_o   = issue ? addr_q : last_addr_q;
   assign bus.data_valid_o = (count_q != '0);
   assign bus.data_o       = buf_data_q[rd_ptr_q];
   assign bus.data_last_o  = bus.data_valid_o && buf_last_q[rd_ptr_q];
   assign bus.done_o       = (state_q == DRAIN) && drained;

   // next state: latch request, issue reads under credit, wait for the buffer to empty
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      last_addr_d = last_addr_q;
      case (state_q)
         IDLE: if (accept) begin
            addr_d  = bus.req_addr_i;
            rem_d   = len_clamped;
            state_d = (len_clamped == '0) ? DRAIN : READ;
         end
         READ: if (issue) begin
            addr_d      = (addr_q == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : addr_q + 1'b1;
            rem_d       = rem_q - 1'b1;
            last_addr_d = addr_q;
            state_d     = (rem_q == LEN_WIDTH'(1)) ? DRAIN : READ;
         end
         DRAIN: if (drained) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         rem_q           <= '0;
         last_addr_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         rem_q           <= rem_d;
         last_addr_q     <= last_addr_d;
         inflight_q      <= issue;
         inflight_last_q <= issue && (rem_q == LEN_WIDTH'(1));
      end
   end

   // 2-entry output buffer capturing RAM data one cycle after each issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_data_q[0] <= '0;
         buf_data_q[1] <= '0;
         buf_last_q    <= '0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         count_q       <= '0;
      end else begin
         if (push) begin
            buf_data_q[wr_ptr_q] <= bus.ram_data_i;
            buf_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push) - 2'(pop);
      end
   end
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: directed bench with a 1-cycle-latency RAM holding mem[i]=i
module tb_ram_burst_reader;
   logic clk, rst_n;
   logic [31:0] mem [256];
   logic [31:0] ram_q;
   int vec_n, err_n;
   int beats[$];
   int en_addr[$];
   int lasts, done_n, en_n, outst, max_out, stab_err;
   int t_acc, t_acc2, t_en, t_val, t_last, t_done, t_dlast, t_rdy;

   ram_burst_reader_if #(.DATA_DEPTH(256), .DATA_WIDTH(32)) bus ();

   ram_burst_reader #(.DATA_DEPTH(256), .DATA_WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // RAM port B: registered read, reset from the same net
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ram_q <= '0;
      else if (bus.ram_en_o) ram_q <= mem[bus.ram_addr_o];
   end
   assign bus.ram_data_i = ram_q;

   task automatic run(input int a1, input int l1, input int a2, input int l2,
                      input int nreq, input bit rnd, input int max_cyc);
      int accs;
      bit stall, en, pp;
      logic [31:0] hold;
      accs = 0; stall = 0; hold = '0;
      beats.delete(); en_addr.delete();
      lasts = 0; done_n = 0; en_n = 0; outst = 0; max_out = 0; stab_err = 0;
      t_acc = -1; t_acc2 = -1; t_en = -1; t_val = -1; t_last = -1;
      t_done = -1; t_dlast = -1; t_rdy = -1;
      bus.req_valid_i = 1; bus.req_addr_i = 8'(a1); bus.req_len_i = 9'(l1);
      for (int c = 0; c < max_cyc && t_rdy < 0; c++) begin
         bus.data_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (stall && (bus.data_valid_o !== 1'b1 || bus.data_o !== hold)) stab_err++;
         if (bus.req_valid_i && bus.req_ready_o) begin
            accs++;
            if (accs == 1) t_acc = c; else t_acc2 = c;
         end
         en = bus.ram_en_o;
         pp = bus.data_valid_o && bus.data_ready_i;
         if (en) begin
            en_n++;
            en_addr.push_back(int'(bus.ram_addr_o));
            if (t_en < 0) t_en = c;
         end
         if (bus.data_valid_o && t_val < 0) t_val = c;
         if (pp) begin
            beats.push_back(int'(bus.data_o));
            if (bus.data_last_o) begin
               lasts++;
               if (t_last < 0) t_last = c;
            end
         end
         outst += int'(en) - int'(pp);
         if (outst > max_out) max_out = outst;
         if (bus.done_o) begin
            done_n++;
            t_dlast = c;
            if (t_done < 0) t_done = c;
         end
         if (done_n == nreq && c > t_dlast && bus.req_ready_o) t_rdy = c;
         stall = bus.data_valid_o && !bus.data_ready_i;
         hold = bus.data_o;
         @(posedge clk); #1;
         if (accs == 1 && nreq == 2) begin
            bus.req_addr_i = 8'(a2); bus.req_len_i = 9'(l2);
         end
         if (accs >= nreq) bus.req_valid_i = 0;
      end
      bus.req_valid_i = 0;
      bus.data_ready_i = 1;
   endtask

   task automatic test_reset;
      rst_n = 0; bus.req_valid_i = 0; bus.req_addr_i = '0; bus.req_len_i = '0; bus.data_ready_i = 0;
      repeat (2) @(negedge clk);
      vec_n++; if (bus.req_ready_o !== 1'b1) begin err_n++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready_o); end
      vec_n++; if (bus.busy_o !== 1'b0) begin err_n++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
      vec_n++; if (bus.ram_en_o !== 1'b0) begin err_n++; $display("FAIL reset_ram_en got %b want 0", bus.ram_en_o); end
      vec_n++; if (bus.ram_addr_o !== 8'd0) begin err_n++; $display("FAIL reset_ram_addr got %0d want 0", bus.ram_addr_o); end
      vec_n++; if (bus.data_valid_o !== 1'b0) begin err_n++; $display("FAIL reset_valid got %b want 0", bus.data_valid_o); end
      vec_n++; if (bus.data_last_o !== 1'b0) begin err_n++; $display("FAIL reset_last got %b want 0", bus.data_last_o); end
      vec_n++; if (bus.data_o !== 32'd0) begin err_n++; $display("FAIL reset_data got %0h want 0", bus.data_o); end
      vec_n++; if (bus.done_o !== 1'b0) begin err_n++; $display("FAIL reset_done got %b want 0", bus.done_o); end
      @(posedge clk); #1;
      rst_n = 1; bus.data_ready_i = 1;
   endtask

   task automatic test_basic;
      run(4, 8, 0, 0, 1, 0, 60);
      vec_n++; if (beats.size() != 8) begin err_n++; $display("FAIL basic_count got %0d want 8", beats.size()); end
      for (int i = 0; i < beats.size() && i < 8; i++) begin
         vec_n++; if (beats[i] != 4 + i) begin err_n++; $display("FAIL basic_beat%0d got %0d want %0d", i, beats[i], 4 + i); end
      end
      vec_n++; if (lasts != 1) begin err_n++; $display("FAIL basic_lasts got %0d want 1", lasts); end
      vec_n++; if (done_n != 1) begin err_n++; $display("FAIL basic_done_n got %0d want 1", done_n); end
      vec_n++; if (t_en - t_acc != 1) begin err_n++; $display("FAIL basic_first_en got T+%0d want T+1", t_en - t_acc); end
      vec_n++; if (t_val - t_acc != 3) begin err_n++; $display("FAIL basic_first_valid got T+%0d want T+3", t_val - t_acc); end
      vec_n++; if (t_last - t_acc != 10) begin err_n++; $display("FAIL basic_last_beat got T+%0d want T+10", t_last - t_acc); end
      vec_n++; if (t_done - t_acc != 11) begin err_n++; $display("FAIL basic_done got T+%0d want T+11", t_done - t_acc); end
      vec_n++; if (t_rdy - t_acc != 12) begin err_n++; $display("FAIL basic_ready got T+%0d want T+12", t_rdy - t_acc); end
      vec_n++; if (en_n != 8) begin err_n++; $display("FAIL basic_en_n got %0d want 8", en_n); end
   endtask

   task automatic test_wrap;
      int exp_v [4];
      exp_v = '{254, 255, 0, 1};
      run(254, 4, 0, 0, 1, 0, 60);
      vec_n++; if (beats.size() != 4 || en_addr.size() != 4) begin err_n++; $display("FAIL wrap_count got %0d/%0d want 4/4", beats.size(), en_addr.size()); end
      for (int i = 0; i < 4 && i < beats.size() && i < en_addr.size(); i++) begin
         vec_n++; if (beats[i] != exp_v[i]) begin err_n++; $display("FAIL wrap_beat%0d got %0d want %0d", i, beats[i], exp_v[i]); end
         vec_n++; if (en_addr[i] != exp_v[i]) begin err_n++; $display("FAIL wrap_addr%0d got %0d want %0d", i, en_addr[i], exp_v[i]); end
      end
      vec_n++; if (t_rdy < 0) begin err_n++; $display("FAIL wrap_timeout got no ready want ready"); end
   endtask

   task automatic test_backpressure;
      run(0, 16, 0, 0, 1, 1, 400);
      vec_n++; if (beats.size() != 16) begin err_n++; $display("FAIL bp_count got %0d want 16", beats.size()); end
      for (int i = 0; i < beats.size() && i < 16; i++) begin
         vec_n++; if (beats[i] != i) begin err_n++; $display("FAIL bp_beat%0d got %0d want %0d", i, beats[i], i); end
      end
      vec_n++; if (stab_err != 0) begin err_n++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
      vec_n++; if (max_out > 2) begin err_n++; $display("FAIL bp_outstanding got %0d want <=2", max_out); end
      vec_n++; if (lasts != 1) begin err_n++; $display("FAIL bp_lasts got %0d want 1", lasts); end
      vec_n++; if (done_n != 1) begin err_n++; $display("FAIL bp_done_n got %0d want 1", done_n); end
   endtask

   task automatic test_len_edges;
      run(7, 0, 0, 0, 1, 0, 20);
      vec_n++; if (en_n != 0) begin err_n++; $display("FAIL zero_en got %0d want 0", en_n); end
      vec_n++; if (beats.size() != 0) begin err_n++; $display("FAIL zero_beats got %0d want 0", beats.size()); end
      vec_n++; if (t_done - t_acc != 1) begin err_n++; $display("FAIL zero_done got T+%0d want T+1", t_done - t_acc); end
      vec_n++; if (t_rdy - t_acc != 2) begin err_n++; $display("FAIL zero_ready got T+%0d want T+2", t_rdy - t_acc); end
      vec_n++; if (done_n != 1) begin err_n++; $display("FAIL zero_done_n got %0d want 1", done_n); end
      run(0, 300, 0, 0, 1, 0, 400);
      vec_n++; if (beats.size() != 256) begin err_n++; $display("FAIL clamp_count got %0d want 256", beats.size()); end
      vec_n++; if (en_n != 256) begin err_n++; $display("FAIL clamp_en got %0d want 256", en_n); end
      for (int i = 0; i < beats.size() && i < 256; i++) begin
         vec_n++; if (beats[i] != i) begin err_n++; $display("FAIL clamp_beat%0d got %0d want %0d", i, beats[i], i); end
      end
      vec_n++; if (lasts != 1) begin err_n++; $display("FAIL clamp_lasts got %0d want 1", lasts); end
   endtask

   task automatic test_reset_mid;
      int n, dn;
      n = 0; dn = 0;
      bus.req_valid_i = 1; bus.req_addr_i = 8'd20; bus.req_len_i = 9'd8; bus.data_ready_i = 1;
      for (int c = 0; c < 50 && n < 3; c++) begin
         @(negedge clk);
         if (bus.data_valid_o && bus.data_ready_i) n++;
         @(posedge clk); #1;
         bus.req_valid_i = 0;
      end
      vec_n++; if (n != 3) begin err_n++; $display("FAIL rstmid_beats got %0d want 3", n); end
      rst_n = 0;
      @(negedge clk);
      vec_n++; if (bus.req_ready_o !== 1'b1) begin err_n++; $display("FAIL rstmid_ready got %b want 1", bus.req_ready_o); end
      vec_n++; if (bus.busy_o !== 1'b0) begin err_n++; $display("FAIL rstmid_busy got %b want 0", bus.busy_o); end
      vec_n++; if (bus.ram_en_o !== 1'b0 || bus.ram_addr_o !== 8'd0) begin err_n++; $display("FAIL rstmid_ram got en=%b addr=%0d want 0/0", bus.ram_en_o, bus.ram_addr_o); end
      vec_n++; if (bus.data_valid_o !== 1'b0 || bus.data_last_o !== 1'b0 || bus.data_o !== 32'd0) begin err_n++; $display("FAIL rstmid_stream got v=%b l=%b d=%0h want 0", bus.data_valid_o, bus.data_last_o, bus.data_o); end
      @(posedge clk); #1;
      rst_n = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.done_o || bus.data_valid_o) dn++;
         @(posedge clk); #1;
      end
      vec_n++; if (dn != 0) begin err_n++; $display("FAIL rstmid_leftover got %0d want 0", dn); end
      run(10, 2, 0, 0, 1, 0, 40);
      vec_n++; if (beats.size() != 2) begin err_n++; $display("FAIL rstmid_after_count got %0d want 2", beats.size()); end
      else begin
         vec_n++; if (beats[0] != 10 || beats[1] != 11) begin err_n++; $display("FAIL rstmid_after_data got %0d,%0d want 10,11", beats[0], beats[1]); end
      end
   endtask

   task automatic test_back_to_back;
      int exp_v [5];
      exp_v = '{100, 101, 102, 200, 201};
      run(100, 3, 200, 2, 2, 0, 80);
      vec_n++; if (beats.size() != 5) begin err_n++; $display("FAIL b2b_count got %0d want 5", beats.size()); end
      for (int i = 0; i < 5 && i < beats.size(); i++) begin
         vec_n++; if (beats[i] != exp_v[i]) begin err_n++; $display("FAIL b2b_beat%0d got %0d want %0d", i, beats[i], exp_v[i]); end
      end
      vec_n++; if (done_n != 2) begin err_n++; $display("FAIL b2b_done_n got %0d want 2", done_n); end
      vec_n++; if (lasts != 2) begin err_n++; $display("FAIL b2b_lasts got %0d want 2", lasts); end
      vec_n++; if (t_acc2 != t_done + 1) begin err_n++; $display("FAIL b2b_second_accept got %0d want %0d", t_acc2, t_done + 1); end
   endtask

   initial begin
      vec_n = 0; err_n = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'(i);
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_len_edges();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
      $finish;
   end
endmodule
